npc_csr_trap: RTL
=================

// Module: npc_csr_trap
// PURPOSE
//  Machine-mode CSR file and trap sequencer, downstream of the ecall/mret instruction decode.
//  Consumes the executing instruction and PC and executes CSR ops (csrrw/s/c and their imm forms) on mstatus/mtvec/mepc/mcause.
//  On ecall it updates the trap CSRs, and on mret it restores them.
//  It then issues a one-cycle PC redirect to the IFU and stalls the issue path while the redirect is in flight.
// PARAMETERS
//  XLEN          32            data/PC width
//  RST_MSTATUS   32'h0000_1800 mstatus reset value (MPP=M)
//  ECALL_CAUSE   32'd11        mcause written on ecall (env call from M)
// PORTS
//  clk            in   1     single clock, all state on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  inst_valid     in   1     inst/pc/rs1_data valid this cycle
//  inst_ready     out  1     block accepts inst this cycle (valid&ready = accepted)
//  inst           in   32    instruction word
//  pc             in   XLEN  PC of inst
//  rs1_data       in   XLEN  GPR[rs1] value
//  csr_rdata      out  XLEN  old CSR value for rd writeback (combinational)
//  csr_rd_we      out  1     write csr_rdata to GPR[rd] (accepted CSR op, rd!=0)
//  redirect_valid out  1     one-cycle pulse: IFU must load redirect_pc
//  redirect_pc    out  XLEN  trap vector (ecall) or mepc (mret)
//  ecall_pulse    out  1     one-cycle pulse on accepted ecall (to DPI event hook)
//  mret_pulse     out  1     one-cycle pulse on accepted mret
// BEHAVIOUR
//  Decode: ecall = inst==32'h0000_0073; mret = inst==32'h3020_0073.
//   CSR op = opcode 7'h73 with funct3 in {1,2,3,5,6,7}; csr addr = inst[31:20].
//   Operand = rs1_data for funct3 1-3, zero-extended inst[19:15] for 5-7.
//  CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. Any other addr reads 0; writes dropped.
//   mtvec[1:0] and mepc[1:0] are hard-wired 0; writes to those bits are ignored.
//  FSM states IDLE, TRAP, RET. Reset -> IDLE.
//   inst_ready = (state==IDLE).
//  IDLE, accepted CSR op: csr_rdata = current value, csr_rd_we=1 iff rd!=0, same cycle.
//   The CSR updates at the clock edge; state stays IDLE.
//   RW (1/5) always writes. RS (2/6) sets bits, RC (3/7) clears bits.
//   RS/RC write nothing when the operand field (rs1 idx / zimm) is 0.
//  IDLE, accepted ecall:
//   mepc<=pc, mcause<=ECALL_CAUSE, mstatus.MPIE<=MIE, MIE<=0, MPP<=2'b11.
//   ecall_pulse=1 this cycle. Next state TRAP.
//  IDLE, accepted mret:
//   mstatus.MIE<=MPIE, MPIE<=1, MPP stays 2'b11. mret_pulse=1 this cycle. Next state RET.
//  TRAP: redirect_valid=1, redirect_pc=mtvec. Next IDLE.
//  RET: redirect_valid=1, redirect_pc=mepc. Next IDLE.
//   Redirect latency = exactly 1 cycle after acceptance.
//   inst_ready is low for that one cycle, and inst_valid is ignored while it is low.
//  Back-to-back: an ecall accepted in the cycle after a redirect is legal, and mepc takes the new pc.
//  An accepted CSR write to mtvec/mepc followed by ecall/mret: the redirect uses the updated value.
//  Non-CSR/non-system inst: no state change; csr_rd_we=0, csr_rdata=0.
//  Reset (any state, any time): outputs go to these values asynchronously.
//   redirect_valid=0, ecall_pulse=0, mret_pulse=0, csr_rd_we=0, inst_ready=1 (IDLE).
//   CSRs: mstatus=RST_MSTATUS, mtvec=0, mepc=0, mcause=0.
//   A trap in flight is abandoned, and no redirect is issued.
//  csr_rdata, csr_rd_we and the pulses are valid only when inst_valid&inst_ready.
// TESTING
//  1 csrrw x5,mtvec with rs1_data=32'h8000_0103 -> csr_rdata=0, csr_rd_we=1; next read mtvec=32'h8000_0100.
//  2 mtvec=32'h8000_0100, ecall at pc=32'h8000_0040 -> ecall_pulse same cycle.
//    Next cycle redirect_valid=1, redirect_pc=32'h8000_0100.
//    After that: mepc=32'h8000_0040, mcause=11, mstatus=32'h0000_1800 (MIE=0, MPIE=0 from reset).
//  3 Set mstatus.MIE via csrrsi 0x300,8, then ecall, then mret.
//    After ecall: mstatus=32'h0000_1880. After mret: MIE=1, MPIE=1.
//    mret redirect_pc = saved mepc, 1 cycle after accept.
//  4 csrrs x0,mcause,x0 (rs1=0) -> no CSR write, csr_rd_we=0.
//    Read/write of unsupported addr 0x7C0 -> csr_rdata=0, CSRs unchanged.
//  5 Hold inst_valid=1 with ecall on consecutive cycles.
//    -> inst_ready low in TRAP cycle, second ecall accepted in the cycle after.
//    -> two redirect pulses, 2 cycles apart.
//  6 Assert rst_n=0 in TRAP cycle -> redirect_valid drops immediately.
//    -> after release: IDLE, mstatus=32'h0000_1800, mepc=0.

Source files
------------

// File: rtl/npc_csr_trap_if.sv
// Instruction issue and redirect bundle between the issue path,
// the machine-mode CSR/trap block and the IFU.
interface npc_csr_trap_if #(
    parameter int unsigned XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_rd_we;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            ecall_pulse;
    logic            mret_pulse;

    modport master (
        output inst_valid, inst, pc, rs1_data,
        input  inst_ready, csr_rdata, csr_rd_we,
        input  redirect_valid, redirect_pc,
        input  ecall_pulse, mret_pulse
    );

    modport slave (
        input  inst_valid, inst, pc, rs1_data,
        output inst_ready, csr_rdata, csr_rd_we,
        output redirect_valid, redirect_pc,
        output ecall_pulse, mret_pulse
    );
endinterface

// File: rtl/npc_csr_trap.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) and ecall/mret
// trap sequencer issuing a one-cycle PC redirect to the IFU.
module npc_csr_trap #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RST_MSTATUS = 32'h0000_1800,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 32'd11
) (
    input  logic             clk,
    input  logic             rst_n,
    npc_csr_trap_if.slave    bus
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        RET
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  field;
    logic [4:0]  rd;

    logic            ready;
    logic            accept;
    logic            is_ecall;
    logic            is_mret;
    logic            is_csr;
    logic            take_ecall;
    logic            take_mret;
    logic            take_csr;
    logic            op_rw;
    logic            op_rs;
    logic            op_rc;
    logic            csr_we;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];
    assign addr   = bus.inst[31:20];
    assign field  = bus.inst[19:15];
    assign rd     = bus.inst[11:7];

    assign is_ecall = (bus.inst == 32'h0000_0073);
    assign is_mret  = (bus.inst == 32'h3020_0073);
    assign is_csr   = (opcode == 7'h73) && (funct3[1:0] != 2'b00);

    assign ready  = (state == IDLE);
    assign accept = bus.inst_valid & ready & rst_n;

    assign take_ecall = accept & is_ecall;
    assign take_mret  = accept & is_mret;
    assign take_csr   = accept & is_csr;

    assign op_rw = is_csr & (funct3[1:0] == 2'b01);
    assign op_rs = is_csr & (funct3[1:0] == 2'b10);
    assign op_rc = is_csr & (funct3[1:0] == 2'b11);

    assign operand = funct3[2] ? {{(XLEN-5){1'b0}}, field}
                               : bus.rs1_data;

    // Set/clear forms with a zero operand field are pure reads.
    assign csr_we = take_csr & (op_rw | (field != 5'd0));

    // Current value of the addressed CSR; unmapped addresses read 0.
    always_comb begin
        old_val = '0;
        case (addr)
            A_MSTATUS: old_val = mstatus;
            A_MTVEC:   old_val = mtvec;
            A_MEPC:    old_val = mepc;
            A_MCAUSE:  old_val = mcause;
            default:   old_val = '0;
        endcase
    end

    // Value the CSR op would write back.
    always_comb begin
        new_val = old_val;
        unique case (1'b1)
            op_rw:   new_val = operand;
            op_rs:   new_val = old_val | operand;
            op_rc:   new_val = old_val & ~operand;
            default: new_val = old_val;
        endcase
    end

    // CSR storage: trap entry/return side effects and software writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus <= RST_MSTATUS;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (take_ecall) begin
            mepc          <= {bus.pc[XLEN-1:2], 2'b00};
            mcause        <= ECALL_CAUSE;
            mstatus[7]    <= mstatus[3];
            mstatus[3]    <= 1'b0;
            mstatus[12:11] <= 2'b11;
        end else if (take_mret) begin
            mstatus[3]    <= mstatus[7];
            mstatus[7]    <= 1'b1;
            mstatus[12:11] <= 2'b11;
        end else if (csr_we) begin
            case (addr)
                A_MSTATUS: mstatus <= new_val;
                A_MTVEC:   mtvec   <= {new_val[XLEN-1:2], 2'b00};
                A_MEPC:    mepc    <= {new_val[XLEN-1:2], 2'b00};
                A_MCAUSE:  mcause  <= new_val;
                default:   ;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the redirect issued in the cycle after a trap/return.
    always_comb begin
        state_next         = state;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        unique case (state)
            IDLE: begin
                if (take_ecall) begin
                    state_next = TRAP;
                end else if (take_mret) begin
                    state_next = RET;
                end
            end
            TRAP: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mtvec;
                state_next         = IDLE;
            end
            RET: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mepc;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.inst_ready  = ready;
    assign bus.csr_rdata   = take_csr ? old_val : '0;
    assign bus.csr_rd_we   = take_csr & (rd != 5'd0);
    assign bus.ecall_pulse = take_ecall;
    assign bus.mret_pulse  = take_mret;
endmodule
